if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction fetch stage for the 5-stage MIPS pipeline. Owns the program counter and issues in-order requests to instruction memory. Buffers returned words so that no fetched instruction is lost while the IF/ID register is stalled. Drives the instruction/PC pair that the IF/ID register captures. Redirects from branch/jump resolution are applied here.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC of the first fetch after reset.
- BUF_DEPTH, 2: capacity of the fetch buffer; also the maximum number of outstanding requests. Legal values are 2 to 4.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en_i  in  1  IF/ID enable. 1 means IF/ID captures inst_o/pc_o this edge; 0 means stall.
- redirect_i  in  1  branch taken or jump from ID/EX. Flushes the fetch stream.
- redirect_pc_i  in  32  target address; bits [1:0] are ignored.
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  fetch address, word aligned
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response data valid; responses return in order, at least 1 cycle after the grant
- imem_rdata_i  in  32  instruction word
- inst_valid_o  out  1  inst_o/pc_o hold a real instruction
- inst_o  out  32  instruction to IF/ID; 32'h0 (NOP) when not valid
- pc_o  out  32  fetch address + 4 of inst_o; 32'h0 when not valid

## Operation
**Registers and counters**
- fetch_pc: next address to request.
- outstanding: granted requests whose data has not yet returned. Range 0 to BUF_DEPTH.
- discard: outstanding responses that belong to a flushed stream. Always ≤ outstanding.
- Buffer: FIFO of {inst, pc+4} entries, holding up to BUF_DEPTH entries.

**Requests**
- imem_req_o = !rst && !redirect_i && (outstanding + count) < BUF_DEPTH.
- imem_addr_o = fetch_pc.
- On req && gnt: fetch_pc += 4 (wraps modulo 2^32) and outstanding increments.

**Responses**
- On rvalid: outstanding decrements.
- If discard > 0 at that time: discard decrements and the data is dropped.
- Otherwise: push {rdata, addr+4}. The address comes from a per-request PC queue in the FIFO, or is recomputed from a response PC register.

**Output and pop**
- inst_valid_o = buffer not empty. inst_o and pc_o come from the buffer head.
- Pop the head when inst_valid_o && en_i.
- When en_i = 0 the head is held unchanged indefinitely.

**Redirect** (priority over every other event in the same cycle)
- fetch_pc ← {redirect_pc_i[31:2], 2'b00}.
- Buffer cleared, including any push or pop in that cycle.
- discard ← outstanding after this cycle's rvalid decrement. A response arriving in the redirect cycle is itself dropped.
- No request is issued in the redirect cycle.

**State machine**
- Two states: RESET → RUN, leaving RESET on the first cycle with rst = 0.
- RUN continues until rst. The stall condition needs no separate state.

**Reset**
- Reset mid-operation abandons in-flight responses. The memory model is reset together with this block.

## Timing
**Reset values**
- fetch_pc = RESET_PC; outstanding = 0, discard = 0, buffer empty.
- imem_req_o = 0, inst_valid_o = 0, inst_o = 0, pc_o = 0.

**Startup and latency**
- First cycle after rst falls: imem_req_o = 1 with imem_addr_o = RESET_PC.
- With gnt tied high and 1-cycle memory latency:
  - word available at inst_o 2 cycles after its request;
  - sustained throughput 1 instruction per cycle.

**Boundary conditions**
- Stall with full buffer: no requests; buffer contents are stable.
- Simultaneous push and pop on a full buffer is legal; count stays unchanged.
- Redirect with en_i = 1 in the same cycle: the head is considered consumed, but it is the flushed instruction. ID handles squashing it.
- Redirect in the same cycle as rvalid: that word is dropped.
- Combinational paths:
  - redirect_i → imem_req_o is the only input-to-output path.
  - No path from en_i to imem_req_o (credit is counted from registered state).

## Structure
- Shared package mips_pkg holds:
  - NOP_INST = 32'h0000_0000
  - PC_STEP = 32'd4
  - the fetch entry struct {inst[31:0], pc4[31:0]}
- One sub-module: fetch_fifo. A synchronous FIFO parameterised by depth and width, with push, pop, clear, full, empty and count. Clear has priority over push and pop.

## Test plan
- Reset, gnt = 1, 1-cycle latency, en_i = 1 → addresses 0, 4, 8… issued on consecutive cycles. inst_o = mem[0] with pc_o = 4 appears 2 cycles after reset release, then one instruction per cycle.
- Hold en_i = 0 for 5 cycles once 2 words are buffered → imem_req_o stays 0. inst_o/pc_o are unchanged. On release, instructions 0x8 and 0xC follow with none lost or duplicated.
- redirect_i with redirect_pc_i = 32'h0000_0103 while 2 requests are outstanding → both responses are dropped. The next request is at 32'h100, and the first valid output is mem[0x100] with pc_o = 32'h104.
- gnt stalls randomly and latency varies 1–3 cycles → output sequence equals program order; outstanding never exceeds BUF_DEPTH.
- Redirect coincident with rvalid and en_i = 1 → the response word never appears at inst_o; the buffer is empty in the next cycle.
- rst asserted mid-stream with the buffer full → the next cycle shows all outputs 0, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } fetch_entry_t;

    typedef enum logic {
        ST_RESET = 1'b0,
        ST_RUN   = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; clear wins over push and pop in the same cycle.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    input  logic                           clear,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests and
// buffers returned words so a stalled IF/ID never loses an instruction.
//
// state    | meaning
// ST_RESET | held in reset, no requests, buffer empty
// ST_RUN   | fetching; stalls and redirects are handled without extra states
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   resp_pc_q;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] discard_q;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic          req_fire;
    fetch_entry_t  push_entry, head_entry;
    logic          unused_ok;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RESET;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_RESET;
        endcase
    end

    // Credit uses only registered occupancy, keeping en_i off the request path.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req_o  = !rst && !redirect_i && (credit_used < (CW+1)'(BUF_DEPTH));
    assign imem_addr_o = fetch_pc_q;
    assign req_fire    = imem_req_o && imem_gnt_i;
    assign redirect_pc = {redirect_pc_i[31:2], 2'b00};

    assign fifo_push  = imem_rvalid_i && !redirect_i && (discard_q == '0);
    assign fifo_pop   = !fifo_empty && en_i && !redirect_i;
    assign push_entry = '{inst: imem_rdata_i, pc4: resp_pc_q + PC_STEP};

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_q + CW'(req_fire) - CW'(imem_rvalid_i);
            if (redirect_i) begin
                fetch_pc_q <= redirect_pc;
                resp_pc_q  <= redirect_pc;
                discard_q  <= outstanding_q - CW'(imem_rvalid_i);
            end else begin
                if (req_fire) fetch_pc_q <= fetch_pc_q + PC_STEP;
                // Dropped responses do not advance the response PC.
                if (imem_rvalid_i) begin
                    if (discard_q != '0) discard_q <= discard_q - CW'(1);
                    else                 resp_pc_q <= resp_pc_q + PC_STEP;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .clear (redirect_i),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign inst_valid_o = !fifo_empty;
    assign inst_o       = fifo_empty ? NOP_INST : head_entry.inst;
    assign pc_o         = fifo_empty ? 32'h0    : head_entry.pc4;

    assign unused_ok = ^{redirect_pc_i[1:0], fifo_full};

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: a queue-based memory model plus a
// program-order stream model of what IF/ID should see.
module tb_if_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 3;

    logic        clk           = 1'b0;
    logic        rst           = 1'b1;
    logic        en_i          = 1'b0;
    logic        redirect_i    = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        imem_gnt_i    = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i  = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    if_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } pend_t;

    pend_t       pend[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] m_req_pc = RESET_PC;
    logic [31:0] m_exp_pc = RESET_PC;
    int          m_out    = 0;

    int          g_en_pct    = 100;
    int          g_gnt_pct   = 100;
    int          g_lat_min   = 1;
    int          g_lat_max   = 1;
    int          g_redir_pm  = 0;
    bit          g_force_redir     = 0;
    bit          g_redir_on_rvalid = 0;
    bit          g_noreq_chk       = 0;
    bit          g_startup_chk     = 0;
    bit          redir_fired       = 0;
    logic [31:0] g_redir_pc = 32'h0;

    bit          p_rst   = 1;
    bit          p_valid = 0;
    bit          p_en    = 0;
    bit          p_redir = 0;
    logic [31:0] p_inst  = 32'h0;
    logic [31:0] p_pc    = 32'h0;
    int          rel_cyc = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs just after the edge, then check and advance the models.
    task automatic step(input bit do_rst);
        bit          redir;
        logic [31:0] tgt;
        @(posedge clk);
        #1;
        cyc++;
        rst           = do_rst;
        en_i          = ($urandom_range(99) < g_en_pct);
        imem_gnt_i    = ($urandom_range(99) < g_gnt_pct);
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        if (do_rst) begin
            pend.delete();
        end else if (pend.size() > 0 && pend[0].ready <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend[0].addr);
            pend.delete(0);
        end
        redir = !do_rst && (g_force_redir || (g_redir_on_rvalid && imem_rvalid_i) ||
                            ($urandom_range(999) < g_redir_pm));
        tgt   = g_force_redir ? g_redir_pc : $urandom;
        g_force_redir = 0;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        if (redir) redir_fired = 1;
        #1;
        if (do_rst) begin
            chk("req_in_rst", {31'h0, imem_req_o}, 32'h0);
            m_req_pc = RESET_PC;
            m_exp_pc = RESET_PC;
            m_out    = 0;
        end else begin
            if (p_rst) begin
                chk("valid_after_rst", {31'h0, inst_valid_o}, 32'h0);
                chk("inst_after_rst", inst_o, 32'h0);
                chk("pc_after_rst", pc_o, 32'h0);
                chk("first_req", {31'h0, imem_req_o}, 32'h1);
                chk("first_addr", imem_addr_o, RESET_PC);
                rel_cyc = cyc;
            end
            if (redir)       chk("req_on_redirect", {31'h0, imem_req_o}, 32'h0);
            if (p_redir)     chk("empty_after_redirect", {31'h0, inst_valid_o}, 32'h0);
            if (g_noreq_chk) chk("no_req_full_stall", {31'h0, imem_req_o}, 32'h0);
            if (p_valid && !p_en && !p_redir && !p_rst) begin
                chk("hold_valid", {31'h0, inst_valid_o}, 32'h1);
                chk("hold_inst", inst_o, p_inst);
                chk("hold_pc", pc_o, p_pc);
            end
            if (g_startup_chk && (cyc - rel_cyc) < 10)
                chk("startup_valid", {31'h0, inst_valid_o}, {31'h0, (cyc - rel_cyc) >= 2});
            if (!inst_valid_o) begin
                chk("nop_inst", inst_o, NOP_INST);
                chk("nop_pc", pc_o, 32'h0);
            end
            if (imem_rvalid_i) m_out--;
            if (imem_req_o && imem_gnt_i) begin
                chk("req_addr", imem_addr_o, m_req_pc);
                pend.push_back('{addr: imem_addr_o,
                                 ready: cyc + int'($urandom_range(g_lat_max, g_lat_min))});
                m_req_pc += 32'd4;
                m_out++;
                chk("outstanding_bound", {31'h0, m_out <= DEPTH}, 32'h1);
            end
            if (inst_valid_o && en_i && !redir) begin
                chk("inst", inst_o, mem_word(m_exp_pc));
                chk("pc", pc_o, m_exp_pc + 32'd4);
                m_exp_pc += 32'd4;
            end
            if (redir) begin
                m_req_pc = {tgt[31:2], 2'b00};
                m_exp_pc = {tgt[31:2], 2'b00};
            end
        end
        p_rst   = do_rst;
        p_valid = inst_valid_o;
        p_en    = en_i;
        p_redir = redir;
        p_inst  = inst_o;
        p_pc    = pc_o;
    endtask

    initial begin
        repeat (3) step(1'b1);

        // Startup latency and back-to-back delivery.
        g_startup_chk = 1;
        repeat (20) step(1'b0);
        g_startup_chk = 0;

        // Stall until the buffer fills, then release.
        g_en_pct = 0;
        repeat (2) step(1'b0);
        g_noreq_chk = 1;
        repeat (3) step(1'b0);
        g_noreq_chk = 0;
        g_en_pct = 100;
        repeat (10) step(1'b0);

        // Redirect to an unaligned target with requests in flight.
        g_lat_min = 3;
        g_lat_max = 3;
        repeat (4) step(1'b0);
        g_force_redir = 1;
        g_redir_pc    = 32'h0000_0103;
        step(1'b0);
        g_lat_min = 1;
        g_lat_max = 1;
        repeat (15) step(1'b0);

        // Random grant stalls, latencies, enables and redirects.
        g_en_pct   = 70;
        g_gnt_pct  = 60;
        g_lat_max  = 3;
        g_redir_pm = 15;
        repeat (800) step(1'b0);
        g_redir_pm = 0;

        // Redirect landing exactly on a response cycle with en_i high.
        g_en_pct  = 100;
        g_gnt_pct = 100;
        for (int k = 0; k < 3; k++) begin
            repeat (5) step(1'b0);
            redir_fired       = 0;
            g_redir_on_rvalid = 1;
            for (int i = 0; i < 50 && !redir_fired; i++) step(1'b0);
            g_redir_on_rvalid = 0;
            chk("redirect_on_rvalid_seen", {31'h0, redir_fired}, 32'h1);
        end

        // Reset with a full buffer, then restart.
        g_lat_max = 1;
        g_en_pct  = 0;
        repeat (6) step(1'b0);
        chk("full_before_rst", {31'h0, inst_valid_o}, 32'h1);
        step(1'b1);
        g_en_pct = 100;
        repeat (20) step(1'b0);
        g_en_pct  = 70;
        g_gnt_pct = 70;
        g_lat_max = 3;
        repeat (200) step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
